// File: rtl/video_scandbl.sv
// video_scandbl: two-bank line buffer that replays each 7 MHz TV line twice at 14 MHz.
// Read path is two stages: registered buffer read, then blanked output register.
module video_scandbl #(
  parameter int DW   = 8,
  parameter int HVIS = 360,
  parameter int UCW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c3,
  input  logic          f1,
  input  logic          vga_on,
  input  logic [9:0]    vga_cnt_in,
  input  logic [9:0]    vga_cnt_out,
  input  logic          vga_hblank,
  input  logic          vga_vblank,
  input  logic          tv_hblank,
  input  logic          tv_vblank,
  input  logic [DW-1:0] pix_in,
  output logic [DW-1:0] pix_out,
  output logic          blank_out,
  output logic          line_ok,
  output logic [UCW-1:0] underrun_cnt,
  input  logic          underrun_clr
);
  localparam logic [8:0] HV   = 9'(HVIS);
  localparam logic [8:0] LAST = 9'(HVIS - 1);
  logic [DW-1:0] mem [2][HVIS];
  logic [DW-1:0] rd_q, pix_q;
  logic [1:0] valid_q, valid_d;
  logic [1:0][1:0] pass_q, pass_d;
  logic [UCW-1:0] urun_q, urun_d;
  logic s1_q, s1_blank_q, s1_valid_q, blank_q, line_ok_q;
  logic wb, rb, we, rd, r_valid, inc, urun, vblk;
  logic [8:0] wa, ra;
  assign wb      = vga_cnt_in[9];
  assign wa      = vga_cnt_in[8:0];
  assign rb      = vga_cnt_out[9];
  assign ra      = vga_cnt_out[8:0];
  // Blanking underflow makes the write counter wrap above HVIS; those must not write.
  assign we      = c3 & (wa < HV);
  assign rd      = f1 & vga_on;
  assign vblk    = vga_hblank | vga_vblank;
  assign r_valid = valid_q[rb];
  assign inc     = rd & r_valid & (ra == LAST);
  assign urun    = rd & ~vblk & (ra < HV) & ~r_valid;
  always_comb begin
    valid_d = valid_q;
    pass_d  = pass_q;
    if (inc) begin
      pass_d[rb] = (pass_q[rb] == 2'd3) ? 2'd3 : pass_q[rb] + 2'd1;
      if (pass_d[rb][1]) valid_d[rb] = 1'b0;
    end
    if (we && wa == 9'd0) begin
      valid_d[wb] = 1'b0;
      pass_d[wb]  = 2'd0;
    end
    if (we && wa == LAST) valid_d[wb] = 1'b1;
    urun_d = underrun_clr ? '0 : (urun && !(&urun_q)) ? urun_q + 1'b1 : urun_q;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wb][wa] <= pix_in;
    if (rd) rd_q <= mem[rb][ra];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      pass_q     <= '0;
      urun_q     <= '0;
      s1_q       <= 1'b0;
      s1_blank_q <= 1'b1;
      s1_valid_q <= 1'b0;
      pix_q      <= '0;
      blank_q    <= 1'b1;
      line_ok_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pass_q  <= pass_d;
      urun_q  <= urun_d;
      s1_q    <= rd;
      if (rd) begin
        s1_blank_q <= vblk | (ra >= HV) | ~r_valid;
        s1_valid_q <= r_valid;
      end
      if (!vga_on && c3) begin
        pix_q   <= pix_in;
        blank_q <= tv_hblank | tv_vblank;
      end else if (s1_q) begin
        pix_q     <= s1_blank_q ? '0 : rd_q;
        blank_q   <= s1_blank_q;
        line_ok_q <= s1_valid_q;
      end
    end
  end
  assign pix_out      = pix_q;
  assign blank_out    = blank_q;
  assign line_ok      = line_ok_q;
  assign underrun_cnt = urun_q;
endmodule

// File: tb/tb_video_scandbl.sv
// tb_video_scandbl: directed bench for the line doubler with hand-computed expectations.
module tb_video_scandbl;
  logic clk = 1'b0, rst_n = 1'b0, c3 = 1'b0, f1 = 1'b0, vga_on = 1'b0;
  logic [9:0] vga_cnt_in = '0, vga_cnt_out = '0;
  logic vga_hblank = 1'b0, vga_vblank = 1'b0, tv_hblank = 1'b0, tv_vblank = 1'b0;
  logic [7:0] pix_in = '0, pix_out, underrun_cnt;
  logic blank_out, line_ok, underrun_clr = 1'b0;
  int n_cmp = 0, n_bad = 0, bad;
  video_scandbl dut (
    .clk(clk), .rst_n(rst_n), .c3(c3), .f1(f1), .vga_on(vga_on),
    .vga_cnt_in(vga_cnt_in), .vga_cnt_out(vga_cnt_out),
    .vga_hblank(vga_hblank), .vga_vblank(vga_vblank),
    .tv_hblank(tv_hblank), .tv_vblank(tv_vblank),
    .pix_in(pix_in), .pix_out(pix_out), .blank_out(blank_out),
    .line_ok(line_ok), .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic b, input int a, input logic [7:0] d);
    vga_cnt_in = {b, 9'(a)};
    pix_in = d;
    c3 = 1'b1;
    @(posedge clk); #1;
    c3 = 1'b0;
  endtask
  task automatic rd(input logic b, input int a);
    vga_cnt_out = {b, 9'(a)};
    f1 = 1'b1;
    @(posedge clk); #1;
    f1 = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    #12;
    chk("rst_pix", pix_out, 0);
    chk("rst_blank", blank_out, 1);
    chk("rst_line_ok", line_ok, 0);
    chk("rst_urun", underrun_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vga_on = 1'b1;
    for (int a = 0; a < 360; a++) wr(1'b0, a, 8'(a));
    for (int p = 0; p < 2; p++) begin
      bad = 0;
      for (int a = 0; a < 360; a++) begin
        rd(1'b0, a);
        if (pix_out !== 8'(a) || blank_out !== 1'b0 || line_ok !== 1'b1) bad++;
      end
      chk(p == 0 ? "pass1_errs" : "pass2_errs", bad, 0);
    end
    chk("pass2_urun", underrun_cnt, 0);
    bad = 0;
    for (int a = 0; a < 360; a++) begin
      rd(1'b0, a);
      if (pix_out !== 8'h00 || blank_out !== 1'b1) bad++;
    end
    chk("pass3_errs", bad, 0);
    chk("pass3_line_ok", line_ok, 0);
    chk("pass3_urun_sat", underrun_cnt, 255);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    chk("urun_clr", underrun_cnt, 0);
    vga_hblank = 1'b1;
    rd(1'b1, 5);
    vga_hblank = 1'b0;
    chk("hblank_blank", blank_out, 1);
    chk("hblank_no_urun", underrun_cnt, 0);
    rd(1'b1, 400);
    chk("oob_blank", blank_out, 1);
    chk("oob_no_urun", underrun_cnt, 0);
    bad = 0;
    for (int a = 0; a < 100; a++) begin
      rd(1'b1, a);
      if (blank_out !== 1'b1 || pix_out !== 8'h00) bad++;
    end
    chk("bank1_errs", bad, 0);
    chk("bank1_urun100", underrun_cnt, 100);
    for (int a = 0; a < 300; a++) rd(1'b1, a % 360);
    chk("bank1_urun_sat", underrun_cnt, 255);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    chk("urun_clr2", underrun_cnt, 0);
    for (int a = 0; a <= 200; a++) wr(1'b0, a, 8'(a) ^ 8'h5A);
    rd(1'b0, 50);
    chk("partial_blank", blank_out, 1);
    chk("partial_line_ok", line_ok, 0);
    chk("partial_pix", pix_out, 0);
    chk("partial_urun", underrun_cnt, 1);
    for (int a = 201; a < 360; a++) wr(1'b0, a, 8'(a) ^ 8'h5A);
    rd(1'b0, 50);
    chk("full_line_ok", line_ok, 1);
    chk("full_blank", blank_out, 0);
    chk("full_pix", pix_out, 8'd50 ^ 8'h5A);
    for (int a = 360; a < 512; a++) wr(1'b0, a, 8'hEE);
    bad = 0;
    for (int a = 0; a < 360; a++) begin
      rd(1'b0, a);
      if (pix_out !== (8'(a) ^ 8'h5A) || blank_out !== 1'b0) bad++;
    end
    chk("wrap_write_errs", bad, 0);
    wr(1'b0, 100, 8'h11);
    vga_cnt_in = {1'b0, 9'd100};
    pix_in = 8'h22;
    vga_cnt_out = {1'b0, 9'd100};
    c3 = 1'b1;
    f1 = 1'b1;
    @(posedge clk); #1;
    c3 = 1'b0;
    f1 = 1'b0;
    @(posedge clk); #1;
    chk("same_clk_old", pix_out, 8'h11);
    rd(1'b0, 100);
    chk("same_clk_new", pix_out, 8'h22);
    vga_on = 1'b0;
    wr(1'b1, 511, 8'hA5);
    chk("bypass_pix", pix_out, 8'hA5);
    chk("bypass_blank", blank_out, 0);
    tv_vblank = 1'b1;
    wr(1'b1, 511, 8'hA5);
    chk("bypass_vblank", blank_out, 1);
    tv_vblank = 1'b0;
    vga_on = 1'b1;
    vga_cnt_out = {1'b0, 9'd50};
    f1 = 1'b1;
    @(posedge clk); #1;
    f1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pix", pix_out, 0);
    chk("async_rst_blank", blank_out, 1);
    chk("async_rst_line_ok", line_ok, 0);
    chk("async_rst_urun", underrun_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1'b0, 50);
    chk("post_rst_blank", blank_out, 1);
    chk("post_rst_line_ok", line_ok, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
